mult_seq_control: RTL and testbench

//  Sequencer for the shift-add multiplier datapath; successor to the fixed 64-bit, 1-bit/cycle controller.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_digit_decode.sv | 57 +++++
 rtl/mult_seq_control.sv | 108 ++++++++++
 tb/tb_mult_seq_control.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared encodings for the sequential shift-add multiplier controller.
package mult_pkg;

  // Controller state encoding (2-bit)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_OP   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Multiple of the multiplicand selected on the datapath adder input
  localparam logic [1:0] MUL_0  = 2'd0;
  localparam logic [1:0] MUL_1X = 2'd1;
  localparam logic [1:0] MUL_2X = 2'd2;
  localparam logic [1:0] MUL_3X = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_OP   = ST_OP,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/mult_digit_decode.sv
// Multiplier digit decoder: maps the multiplier LSBs seen this OP cycle to
// an accumulate command (enable, multiple of multiplicand, subtract).
// The top-most digit of a signed operand carries negative weight, which is
// why the last cycle with the signed latch set is decoded differently.
module mult_digit_decode
  import mult_pkg::*;
#(
  parameter bit RADIX4 = 1'b0
) (
  input  logic [1:0] data_in,
  input  logic       last,
  input  logic       signed_op,
  output logic       wr,
  output logic [1:0] add_mult,
  output logic       sub
);

  // Decode one radix-2 or radix-4 digit into an add/subtract command
  always_comb begin
    wr       = 1'b0;
    add_mult = MUL_0;
    sub      = 1'b0;
    if (RADIX4) begin
      if (last && signed_op) begin
        // Sign digit: bit 1 has weight -2, so 10 = -2 and 11 = -1
        case (data_in)
          2'b01: begin
            wr       = 1'b1;
            add_mult = MUL_1X;
          end
          2'b10: begin
            wr       = 1'b1;
            add_mult = MUL_2X;
            sub      = 1'b1;
          end
          2'b11: begin
            wr       = 1'b1;
            add_mult = MUL_1X;
            sub      = 1'b1;
          end
          default: ;
        endcase
      end else begin
        wr       = |data_in;
        add_mult = data_in;
      end
    end else begin
      // Radix-2: only bit 0 matters; the sign bit is subtracted
      if (data_in[0]) begin
        wr       = 1'b1;
        add_mult = MUL_1X;
        sub      = last & signed_op;
      end
    end
  end

endmodule

// File: rtl/mult_seq_control.sv
// Sequencer for the shift-add multiplier datapath. Walks IDLE -> LOAD ->
// N_OP shift/accumulate cycles -> DONE, with abort and a one-cycle done pulse.
// All outputs are decoded from state/counter/data_in so that an asynchronous
// reset forces them to their idle values immediately.
// WIDTH must be even when RADIX4=1.
module mult_seq_control
  import mult_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit RADIX4 = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       signed_op,
  input  logic       abort,
  input  logic [1:0] data_in,
  output logic       ready,
  output logic       busy,
  output logic       initial_wr,
  output logic       wr,
  output logic [1:0] add_mult,
  output logic       sub,
  output logic       sh_right,
  output logic       sh_amt,
  output logic       done
);

  localparam int N_OP = RADIX4 ? WIDTH / 2 : WIDTH;
  // Keep at least one counter bit so a degenerate N_OP=1 still elaborates
  localparam int CW = (N_OP > 1) ? $clog2(N_OP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_OP - 1);

  state_e          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            signed_reg;

  logic            in_op;
  logic            last_op;
  logic            dec_wr;
  logic [1:0]      dec_add_mult;
  logic            dec_sub;

  // Controller FSM and OP-cycle counter; signed mode is captured with start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      signed_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_LOAD;
            signed_reg <= signed_op;
          end
        end
        S_LOAD: begin
          cnt_reg   <= '0;
          state_reg <= abort ? S_IDLE : S_OP;
        end
        S_OP: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            // Exit before the counter could wrap
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign in_op   = (state_reg == S_OP);
  assign last_op = in_op && (cnt_reg == CNT_LAST);

  mult_digit_decode #(
    .RADIX4 (RADIX4)
  ) u_digit_decode (
    .data_in   (data_in),
    .last      (last_op),
    .signed_op (signed_reg),
    .wr        (dec_wr),
    .add_mult  (dec_add_mult),
    .sub       (dec_sub)
  );

  // Accumulate commands are only meaningful while shifting
  assign wr         = in_op & dec_wr;
  assign add_mult   = in_op ? dec_add_mult : MUL_0;
  assign sub        = in_op & dec_sub;

  assign ready      = (state_reg == S_IDLE);
  assign busy       = (state_reg == S_LOAD) || in_op;
  assign initial_wr = (state_reg == S_LOAD);
  assign sh_right   = in_op;
  assign sh_amt     = in_op & RADIX4;
  assign done       = (state_reg == S_DONE);

endmodule

// File: tb/tb_mult_seq_control.sv
// Self-checking bench for mult_seq_control: one radix-2 and one radix-4
// instance (WIDTH=8). Per-cycle expected output bundles are pushed to a
// scoreboard queue as stimulus is driven and popped at the falling edge.
module tb_mult_seq_control;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       initial_wr;
    logic       wr;
    logic [1:0] add_mult;
    logic       sub;
    logic       sh_right;
    logic       sh_amt;
    logic       done;
  } out_t;

  typedef struct {
    bit              r4;
    bit              sgn;
    bit              sgn_after;
    bit              hold;
    logic [7:0][1:0] digs;
    int              abort_at;   // -2 none, -1 during LOAD, >=0 OP index
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // radix-2 instance signals
  logic       start_a, signed_a, abort_a;
  logic [1:0] din_a;
  logic       ready_a, busy_a, iwr_a, wr_a, sub_a, shr_a, sha_a, done_a;
  logic [1:0] am_a;
  // radix-4 instance signals
  logic       start_b, signed_b, abort_b;
  logic [1:0] din_b;
  logic       ready_b, busy_b, iwr_b, wr_b, sub_b, shr_b, sha_b, done_b;
  logic [1:0] am_b;

  out_t out_a, out_b;
  assign out_a = {ready_a, busy_a, iwr_a, wr_a, am_a, sub_a, shr_a, sha_a, done_a};
  assign out_b = {ready_b, busy_b, iwr_b, wr_b, am_b, sub_b, shr_b, sha_b, done_b};

  mult_seq_control #(.WIDTH(8), .RADIX4(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .signed_op(signed_a),
    .abort(abort_a), .data_in(din_a), .ready(ready_a), .busy(busy_a),
    .initial_wr(iwr_a), .wr(wr_a), .add_mult(am_a), .sub(sub_a),
    .sh_right(shr_a), .sh_amt(sha_a), .done(done_a)
  );

  mult_seq_control #(.WIDTH(8), .RADIX4(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .signed_op(signed_b),
    .abort(abort_b), .data_in(din_b), .ready(ready_b), .busy(busy_b),
    .initial_wr(iwr_b), .wr(wr_b), .add_mult(am_b), .sub(sub_b),
    .sh_right(shr_b), .sh_amt(sha_b), .done(done_b)
  );

  out_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // ---------------- expected-value helpers ----------------
  function automatic out_t o_idle();
    out_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic out_t o_load();
    out_t o = '0;
    o.busy       = 1'b1;
    o.initial_wr = 1'b1;
    return o;
  endfunction

  function automatic out_t o_done();
    out_t o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  // Signed digit value: the top digit of a signed operand has negative weight
  function automatic out_t o_op(bit r4, bit sgn, bit last, logic [1:0] d);
    out_t o = '0;
    int   v;
    v = r4 ? int'(d) : int'(d[0]);
    if (sgn && last) begin
      if (r4) v = d[1] ? int'(d) - 4 : int'(d);
      else    v = -v;
    end
    o.busy     = 1'b1;
    o.sh_right = 1'b1;
    o.sh_amt   = r4;
    o.wr       = (v != 0);
    o.add_mult = 2'((v < 0) ? -v : v);
    o.sub      = (v < 0);
    return o;
  endfunction

  function automatic vec_t mkv(bit r4, bit sgn, bit sgn_after, bit hold,
                               logic [15:0] digs, int abort_at);
    vec_t v;
    v.r4 = r4; v.sgn = sgn; v.sgn_after = sgn_after; v.hold = hold;
    v.digs = digs; v.abort_at = abort_at;
    return v;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check_out(input string tag, input bit r4, input int cyc);
    out_t got, e;
    got = r4 ? out_b : out_a;
    e   = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_miss++;
      $display("FAIL %s r4=%0d cyc=%0d got=%b required=%b (rdy,bsy,iwr,wr,am[2],sub,shr,sha,done)",
               tag, r4, cyc, got, e);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare at the falling edge
  task automatic drive_cycle(input string tag, input bit r4, input int cyc,
                             input logic st, input logic sg, input logic ab,
                             input logic [1:0] d, input out_t e);
    @(posedge clk);
    #1;
    start_a = r4 ? 1'b0 : st;  signed_a = r4 ? 1'b0 : sg;
    abort_a = r4 ? 1'b0 : ab;  din_a    = r4 ? 2'b00 : d;
    start_b = r4 ? st : 1'b0;  signed_b = r4 ? sg : 1'b0;
    abort_b = r4 ? ab : 1'b0;  din_b    = r4 ? d : 2'b00;
    exp_q.push_back(e);
    @(negedge clk);
    check_out(tag, r4, cyc);
  endtask

  // Apply one table vector: start, LOAD, OP cycles, DONE, trailing IDLE
  task automatic run_vec(input string tag, input vec_t v);
    int  n;
    int  c;
    bit  aborted;
    n = v.r4 ? 4 : 8;
    c = 0;
    aborted = 1'b0;
    drive_cycle(tag, v.r4, c++, 1'b1, v.sgn, 1'b0, 2'b00, o_idle());
    drive_cycle(tag, v.r4, c++, v.hold, v.sgn_after, (v.abort_at == -1), 2'b00, o_load());
    if (v.abort_at == -1) begin
      aborted = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        drive_cycle(tag, v.r4, c++, v.hold, v.sgn_after, (i == v.abort_at),
                    v.digs[i], o_op(v.r4, v.sgn, (i == n - 1), v.digs[i]));
        if (i == v.abort_at) begin
          aborted = 1'b1;
          break;
        end
      end
    end
    if (aborted) begin
      // No done pulse may follow an abort
      drive_cycle(tag, v.r4, c++, 1'b0, v.sgn_after, 1'b0, 2'b00, o_idle());
      drive_cycle(tag, v.r4, c++, 1'b0, v.sgn_after, 1'b0, 2'b00, o_idle());
    end else begin
      // abort is asserted in DONE to confirm it is ignored there
      drive_cycle(tag, v.r4, c++, v.hold, v.sgn_after, 1'b1, 2'b00, o_done());
      drive_cycle(tag, v.r4, c++, v.hold, v.sgn_after, 1'b0, 2'b00, o_idle());
      if (v.hold) begin
        // Held start launches the next op after exactly one ready cycle
        drive_cycle(tag, v.r4, c++, 1'b0, v.sgn_after, 1'b1, 2'b00, o_load());
        drive_cycle(tag, v.r4, c++, 1'b0, v.sgn_after, 1'b0, 2'b00, o_idle());
      end
    end
    $display("vector %s r4=%0d signed=%0d hold=%0d abort_at=%0d cycles=%0d",
             tag, v.r4, v.sgn, v.hold, v.abort_at, c);
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // digit i of each vector lives in bits [2i+1:2i]
    vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, -2); // r2 all ones
    vecs[1]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h001B, -2); // r4 11,10,01,00
    vecs[2]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 16'h00B1, -2); // r4 signed last 10
    vecs[3]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 16'h00C6, -2); // r4 signed last 11
    vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h00B1, -2); // unsigned last 10
    vecs[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h00C6, -2); // unsigned last 11
    vecs[6]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 16'h00B1, -2); // signed dropped after start
    vecs[7]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 16'h00C6, -2); // signed raised after start
    vecs[8]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 16'h5059, -2); // r2 signed last 1, bit1 noise
    vecs[9]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 16'h1555, -2); // r2 signed last 0
    vecs[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 16'h5555,  2); // abort on 3rd OP cycle
    vecs[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 16'h3C96, -2); // full op after abort
    vecs[12] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, -1); // abort in LOAD
    vecs[13] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF,  3); // abort on last OP cycle
    vecs[14] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, -2); // start held, r2
    vecs[15] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 16'h00B1, -2); // start held, r4 signed

    reset = 1'b1;
    start_a = 1'b0; signed_a = 1'b0; abort_a = 1'b0; din_a = 2'b00;
    start_b = 1'b0; signed_b = 1'b0; abort_b = 1'b0; din_b = 2'b00;
    #2;
    exp_q.push_back(o_idle()); check_out("reset_state", 1'b0, 0);
    exp_q.push_back(o_idle()); check_out("reset_state", 1'b1, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      run_vec($sformatf("tbl%0d", k), vecs[k]);
    end

    // Asynchronous reset in the middle of an OP cycle, between clock edges
    drive_cycle("async_rst", 1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b01, o_idle());
    drive_cycle("async_rst", 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b01, o_load());
    drive_cycle("async_rst", 1'b0, 2, 1'b0, 1'b0, 1'b0, 2'b01, o_op(1'b0, 1'b0, 1'b0, 2'b01));
    drive_cycle("async_rst", 1'b0, 3, 1'b0, 1'b0, 1'b0, 2'b01, o_op(1'b0, 1'b0, 1'b0, 2'b01));
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(o_idle()); check_out("async_rst_now", 1'b0, 4);
    exp_q.push_back(o_idle()); check_out("async_rst_now", 1'b1, 4);
    start_a = 1'b0; din_a = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    drive_cycle("after_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, o_idle());
    run_vec("after_rst_op", mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h001B, -2));

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
